ps2_rx_event_fifo: RTL and testbench
====================================

// Module: ps2_rx_event_fifo
// PURPOSE
//  System-clocked PS/2 keyboard receiver; runs on CLK rather than on the PS2_CLK line.
//  Samples PS2_CLK/PS2_DAT and validates each frame: start bit, odd parity, stop bit, timeout.
//  Folds F0 (break) and, optionally, E0 (extended) prefixes into one key event per key action.
//  Buffers events in a parametrised FIFO behind a valid/ready port for the game/display logic.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency, Hz
//  TIMEOUT_US   1000         max gap between PS2_CLK falling edges inside a frame, us
//  SYNC_STAGES  2            synchroniser depth on PS2_CLK/PS2_DAT (>=2)
//  FILTER_LEN   4            consecutive equal samples needed to change the filtered PS2_CLK level
//  FIFO_DEPTH   8            event entries; power of 2, >=2
// PORTS
//  CLK          in   1   system clock
//  RST_N        in   1   asynchronous active-low reset
//  PS2_CLK      in   1   PS/2 clock line, asynchronous
//  PS2_DAT      in   1   PS/2 data line, asynchronous
//  EVT_VALID    out  1   FIFO not empty
//  EVT_READY    in   1   consumer accepts the head event
//  EVT_CODE     out  8   head event scan code
//  EVT_RELEASE  out  1   head event is a key release (F0 seen)
//  EVT_EXT      out  1   head event is extended (E0 seen); tied 0 without PS2_EXT_EN
//  FIFO_LEVEL   out  $clog2(FIFO_DEPTH+1)  entries held
//  OVERFLOW     out  1   sticky; an event was dropped because the FIFO was full
//  CLR_OVF      in   1   synchronous clear of OVERFLOW
//  FRAME_ERR    out  1   1-cycle pulse; a frame was discarded
// BEHAVIOUR
//  Reset is asynchronous and active-low.
//  - Reset: all outputs 0; FSM IDLE; FIFO empty; prefix flags 0; timeout counter 0.
//  - Reset: synchroniser flops and the filtered clock are set to 1 (idle-high), so no false edge.
//  Input conditioning:
//  - Falling edge = filtered clock goes 1->0.
//  - PS2_DAT (synchronised) is sampled in that same cycle.
//  Frame FSM:
//  - IDLE:   edge with DAT=0 -> DATA, bit count 0; edge with DAT=1 -> FRAME_ERR, stay IDLE.
//  - DATA:   shift in LSB first; after the 8th bit -> PARITY.
//  - PARITY: record whether (8 data bits + parity bit) have odd weight -> STOP.
//  - STOP:   DAT=1 and parity ok -> byte accepted; otherwise FRAME_ERR. Either way -> IDLE.
//  Timeout:
//  - TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US.
//  - Counter clears on every falling edge and runs only outside IDLE.
//  - On reaching TIMEOUT_CYC: -> IDLE, FRAME_ERR, prefix flags cleared.
//  Decoder (one cycle after byte acceptance):
//  - F0: set rel_pend. E0: set ext_pend.
//  - 00/FF (keyboard error codes): discard, flags unchanged.
//  - Any other byte: push {ext_pend, rel_pend, byte}, then clear both flags.
//  - Latency: STOP-bit sample cycle to EVT_VALID = 2 CLK cycles when the FIFO was empty.
//  FIFO:
//  - First-word-fall-through; no empty bypass. A push is visible the cycle after it is written.
//  - Pop when EVT_VALID && EVT_READY.
//  - Push when full without a same-cycle pop: event dropped, OVERFLOW set.
//  - Push and pop in the same cycle while full: both succeed, no overflow.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - OVERFLOW set and CLR_OVF in the same cycle: set wins.
//  - EVT_CODE/RELEASE/EXT hold the head entry; they are 0 when empty.
//  - Reset mid-frame or mid-prefix: partial byte and flags lost; the next frame needs a clean start bit.
// CONFIGURATION
//  PS2_EXT_EN defined:
//  - E0 handled as a prefix; EVT_EXT reflects it.
//  - E0 F0 xx yields a single event: EXT=1, RELEASE=1.
//  PS2_EXT_EN undefined:
//  - E0 discarded like 00/FF; ext_pend logic removed; EVT_EXT tied 0.
// TESTING
//  (bench uses CLK_HZ=1_000_000, PS2 bit period 40us)
//  1 frame 0x1C, good parity -> EVT_CODE=1C, RELEASE=0, EXT=0, FIFO_LEVEL=1; pop -> VALID=0.
//  2 frames F0,1C -> exactly one event: CODE=1C, RELEASE=1; no event for F0.
//  3 frame 0x1B with parity flipped -> one FRAME_ERR pulse, no event; next good 0x1B -> event CODE=1B.
//  4 5 data bits then idle >1000us -> FRAME_ERR, FSM IDLE; then full 0x45 -> event CODE=45.
//  5 READY=0, send 9 codes 16,1E..: LEVEL=8, OVERFLOW=1; drain order = first 8; CLR_OVF -> OVERFLOW=0.
//  6 frames E0,F0,75 -> with PS2_EXT_EN: CODE=75, EXT=1, RELEASE=1; without: CODE=75, EXT=0, RELEASE=1.

Source files
------------

// File: rtl/ps2_rx_event_fifo.sv
// PS/2 keyboard receiver on the system clock: frame check, F0/E0 prefix folding, event FIFO.
// Define PS2_EXT_EN to treat E0 as an extended-key prefix; otherwise E0 is discarded and EVT_EXT is 0.
module ps2_rx_event_fifo #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TIMEOUT_US  = 1000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            PS2_CLK,
  input  logic                            PS2_DAT,
  output logic                            EVT_VALID,
  input  logic                            EVT_READY,
  output logic [7:0]                      EVT_CODE,
  output logic                            EVT_RELEASE,
  output logic                            EVT_EXT,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_LEVEL,
  output logic                            OVERFLOW,
  input  logic                            CLR_OVF,
  output logic                            FRAME_ERR
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
`ifdef PS2_EXT_EN
  localparam int unsigned EW = 10;
`else
  localparam int unsigned EW = 9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_filt, clk_filt_d;
  logic [FW-1:0]          flt_cnt;
  logic                   fall, dat_s;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;
  logic          byte_vld, tmo_pulse, frame_err;

  logic          rel_pend, push;
  logic [EW-1:0] entry, head;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, empty, pop, wr, ovf;

  // Idle-high reset on both chains and the filter keeps reset release from looking like an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      clk_filt_d <= clk_filt;
      if (clk_sync[SYNC_STAGES-1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[SYNC_STAGES-1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall  = clk_filt_d & ~clk_filt;
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      tmo_cnt   <= '0;
      byte_vld  <= 1'b0;
      tmo_pulse <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      tmo_pulse <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        unique case (state)
          S_IDLE: begin
            if (!dat_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_ok <= ^{shreg, dat_s};
            state  <= S_STOP;
          end
          S_STOP: begin
            if (dat_s && par_ok) byte_vld  <= 1'b1;
            else                 frame_err <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state     <= S_IDLE;
          tmo_cnt   <= '0;
          frame_err <= 1'b1;
          tmo_pulse <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // shreg holds the accepted byte during the byte_vld cycle, so the decoder reads it directly.
  always_comb begin
    push = byte_vld && !(shreg == 8'hF0 || shreg == 8'hE0 || shreg == 8'h00 || shreg == 8'hFF);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                            rel_pend <= 1'b0;
    else if (tmo_pulse)                    rel_pend <= 1'b0;
    else if (byte_vld && shreg == 8'hF0)   rel_pend <= 1'b1;
    else if (push)                         rel_pend <= 1'b0;
  end

`ifdef PS2_EXT_EN
  logic ext_pend;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                            ext_pend <= 1'b0;
    else if (tmo_pulse)                    ext_pend <= 1'b0;
    else if (byte_vld && shreg == 8'hE0)   ext_pend <= 1'b1;
    else if (push)                         ext_pend <= 1'b0;
  end
  assign entry   = {ext_pend, rel_pend, shreg};
  assign EVT_EXT = empty ? 1'b0 : head[9];
`else
  assign entry   = {rel_pend, shreg};
  assign EVT_EXT = 1'b0;
`endif

  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && EVT_READY;
  assign wr    = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
      else if (CLR_OVF)         ovf <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign EVT_VALID   = !empty;
  assign EVT_CODE    = empty ? '0 : head[7:0];
  assign EVT_RELEASE = empty ? 1'b0 : head[8];
  assign FIFO_LEVEL  = count;
  assign OVERFLOW    = ovf;
  assign FRAME_ERR   = frame_err;

endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// Scoreboard bench for ps2_rx_event_fifo: key actions are encoded to PS/2 frames, expected events queued,
// and a monitor pops and compares whenever the DUT hands over an event.
module tb_ps2_rx_event_fifo;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid, evt_release, evt_ext, overflow, frame_err;
  logic [7:0] evt_code;
  logic [3:0] fifo_level;

  int   checks = 0;
  int   errors = 0;
  int   fe_seen = 0;
  int   fe_exp = 0;
  bit   mon_en = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   rdy_fixed = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_rx_event_fifo #(
    .CLK_HZ(1_000_000), .TIMEOUT_US(1000), .SYNC_STAGES(2), .FILTER_LEN(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .EVT_VALID(evt_valid), .EVT_READY(evt_ready), .EVT_CODE(evt_code),
    .EVT_RELEASE(evt_release), .EVT_EXT(evt_ext), .FIFO_LEVEL(fifo_level),
    .OVERFLOW(overflow), .CLR_OVF(clr_ovf), .FRAME_ERR(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit cell of 40 cycles (40us at 1 MHz): data set while high, clock low for 20.
  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
    cycles(10);
  endtask

  task automatic send_raw(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    cycles(20);
  endtask

  task automatic send_bad(input logic [7:0] b);
    fe_exp++;
    send_raw(b, 1'b1);
  endtask

  // Reference: one key action is one event, whatever prefix bytes carry it on the wire.
  task automatic key_action(input logic [7:0] code, input bit rel, input bit ext);
    logic [9:0] e;
`ifdef PS2_EXT_EN
    e = {ext, rel, code};
`else
    e = {1'b0, rel, code};
`endif
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    if (ext) send_raw(8'hE0, 1'b0);
    if (rel) send_raw(8'hF0, 1'b0);
    send_raw(code, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    rdy_fixed = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cycles(1);
      n++;
    end
    cycles(3);
    check({name, "_remaining"}, exp_q.size(), 0);
    check({name, "_level"}, fifo_level, 0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom_range(1, 254)); while (c == 8'hF0 || c == 8'hE0);
    return c;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      evt_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_err) fe_seen++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", {evt_ext, evt_release, evt_code});
        end else begin
          check("event", {evt_ext, evt_release, evt_code}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] codes [9];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    cycles(3);
    check("rst_valid", evt_valid, 0);
    check("rst_outputs", {evt_code, evt_release, evt_ext, overflow, frame_err}, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cycles(5);

    // single make code
    key_action(8'h1C, 1'b0, 1'b0);
    check("t1_valid", evt_valid, 1);
    check("t1_level", fifo_level, 1);
    check("t1_head", {evt_ext, evt_release, evt_code}, 10'h01C);
    drain("t1");
    check("t1_empty_outputs", {evt_valid, evt_code, evt_release, evt_ext}, 0);

    // break code folds F0 into one event
    rdy_fixed = 1'b0;
    cycles(2);
    key_action(8'h1C, 1'b1, 1'b0);
    check("t2_level", fifo_level, 1);
    drain("t2");

    // bad parity then good frame; lone edge with DAT high
    send_bad(8'h1B);
    check("t3_fe", fe_seen, fe_exp);
    check("t3_level", fifo_level, 0);
    key_action(8'h1B, 1'b0, 1'b0);
    ps2_bit(1'b1);
    fe_exp++;
    cycles(20);
    check("t3_lone_edge_fe", fe_seen, fe_exp);
    drain("t3");

    // truncated frame times out
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    ps2_dat = 1'b1;
    cycles(1100);
    fe_exp++;
    check("t4_timeout_fe", fe_seen, fe_exp);
    key_action(8'h45, 1'b0, 1'b0);
    drain("t4");

    // overflow with consumer stalled
    rdy_fixed = 1'b0;
    cycles(2);
    for (int i = 0; i < 9; i++) key_action(codes[i], 1'b0, 1'b0);
    check("t5_level_full", fifo_level, DEPTH);
    check("t5_overflow", overflow, 1);
    drain("t5");
    check("t5_overflow_sticky", overflow, 1);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    cycles(1);
    check("t5_overflow_cleared", overflow, 0);

    // extended release
    rdy_fixed = 1'b0;
    cycles(2);
    key_action(8'h75, 1'b1, 1'b1);
    check("t6_level", fifo_level, 1);
    drain("t6");

    // randomized actions with noise bytes, bad frames and random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: send_raw($urandom_range(0, 1) ? 8'hFF : 8'h00, 1'b0);
        1: send_bad(8'($urandom_range(0, 255)));
        default: ;
      endcase
      key_action(rand_code(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rdy_rand = 1'b0;
    drain("rand");
    check("rand_fe", fe_seen, fe_exp);
    check("rand_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
